// File: rtl/shared_divider_if.sv
// Request/result bundle between the clients and the shared divider.
// The clients drive the master side and the divider drives the slave side.
interface shared_divider_if #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 12
);
  logic [N_CH-1:0]          req;
  logic [N_CH*IN_WIDTH-1:0] dividend;
  logic [N_CH*IN_WIDTH-1:0] divisor;
  logic [N_CH-1:0]          grant;
  logic [N_CH-1:0]          done;
  logic [OUT_WIDTH-1:0]     quotient;
  logic                     div_zero;
  logic                     sat;
  logic                     busy;

  modport master (
    output req, dividend, divisor,
    input  grant, done, quotient, div_zero, sat, busy
  );

  modport slave (
    input  req, dividend, divisor,
    output grant, done, quotient, div_zero, sat, busy
  );
endinterface

// File: rtl/shared_divider.sv
// N-channel round-robin shared restoring divider, one quotient bit per cycle.
// Optional SHARED_DIVIDER_ROUND_EN rounds to nearest instead of truncating.
module shared_divider #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 12
) (
  input logic            clock,
  input logic            reset,
  shared_divider_if.slave bus
);

  localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);
  localparam int unsigned QW = IN_WIDTH + 1;
  localparam logic [QW-1:0] QMax = {{(QW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ch_q, sel;
  logic                 found;
  logic [IN_WIDTH-1:0]  quo_q, dvs_q, rem_q;
  logic [CW-1:0]        cnt_q;
  logic [OUT_WIDTH-1:0] res_q;
  logic                 dz_q, sat_q;

  logic [QW-1:0]        rem_sh, diff, rem_full, q_full;
  logic                 take;
  logic [IN_WIDTH-1:0]  quo_nx;
  logic [OUT_WIDTH-1:0] res_c;
  logic                 dz_c, sat_c;
`ifdef SHARED_DIVIDER_ROUND_EN
  logic                 round_up;
`endif

  // First requesting channel at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr_q) + i) % N_CH;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  // Restoring step; a zero divisor never subtracts.
  always_comb begin
    rem_sh   = {rem_q, quo_q[IN_WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    take     = (dvs_q != '0) && (rem_sh >= {1'b0, dvs_q});
    rem_full = take ? diff : rem_sh;
    quo_nx   = {quo_q[IN_WIDTH-2:0], take};
  end

  always_comb begin
`ifdef SHARED_DIVIDER_ROUND_EN
    round_up = (dvs_q != '0) && ({rem_q, 1'b0} >= {1'b0, dvs_q});
    q_full   = {1'b0, quo_q} + QW'(round_up);
`else
    q_full   = {1'b0, quo_q};
`endif
    res_c = q_full[OUT_WIDTH-1:0];
    dz_c  = 1'b0;
    sat_c = 1'b0;
    if (dvs_q == '0) begin
      res_c = '1;
      dz_c  = 1'b1;
    end else if (q_full > QMax) begin
      res_c = '1;
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (found) state_d = StDiv;
      StDiv:   if (cnt_q == CW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      ch_q  <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      dz_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            quo_q <= bus.dividend[int'(sel)*IN_WIDTH +: IN_WIDTH];
            dvs_q <= bus.divisor[int'(sel)*IN_WIDTH +: IN_WIDTH];
            rem_q <= '0;
            ch_q  <= sel;
            cnt_q <= CW'(IN_WIDTH);
          end
        end
        StDiv: begin
          quo_q <= quo_nx;
          rem_q <= IN_WIDTH'(rem_full);
          cnt_q <= cnt_q - 1'b1;
        end
        StDone: begin
          res_q <= res_c;
          dz_q  <= dz_c;
          sat_q <= sat_c;
          ptr_q <= (ch_q == PW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Grant is combinational so done can fall in the DONE cycle itself.
  always_comb begin
    bus.grant    = '0;
    bus.done     = '0;
    bus.busy     = (state_q != StIdle);
    bus.quotient = res_q;
    bus.div_zero = dz_q;
    bus.sat      = sat_q;
    if (state_q == StIdle && found && !reset) bus.grant[sel] = 1'b1;
    if (state_q == StDone) begin
      bus.done[ch_q] = 1'b1;
      bus.quotient   = res_c;
      bus.div_zero   = dz_c;
      bus.sat        = sat_c;
    end
  end

endmodule

// File: tb/tb_shared_divider.sv
// Directed bench for shared_divider: latency, arithmetic, arbitration and reset.
module tb_shared_divider;
  localparam int unsigned N_CH = 2, IW = 16, OW = 12;
`ifdef SHARED_DIVIDER_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n;
  logic seen;

  always #5 clock = ~clock;

  shared_divider_if #(.N_CH(N_CH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  shared_divider #(.N_CH(N_CH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done == '0 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input int ch, input int a, input int b,
                       input int eq, input int edz, input int esat);
    int c;
    @(negedge clock);
    bus.dividend[ch*IW +: IW] = a[IW-1:0];
    bus.divisor[ch*IW +: IW]  = b[IW-1:0];
    bus.req[ch]               = 1'b1;
    #1;
    chk({tag, ".grant"}, bus.grant, 32'(1 << ch));
    wait_done(c);
    chk({tag, ".latency"}, c, 17);
    chk({tag, ".done"}, bus.done, 32'(1 << ch));
    chk({tag, ".quotient"}, bus.quotient, eq);
    chk({tag, ".div_zero"}, bus.div_zero, edz);
    chk({tag, ".sat"}, bus.sat, esat);
    chk({tag, ".busy"}, bus.busy, 1);
    @(negedge clock);
    bus.req[ch] = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clock);
    chk("rst.grant", bus.grant, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.quotient", bus.quotient, 0);
    chk("rst.div_zero", bus.div_zero, 0);
    chk("rst.sat", bus.sat, 0);
    chk("rst.busy", bus.busy, 0);
    reset = 1'b0;

    // Simultaneous requests straight after reset: ch0 first, then ch1.
    @(negedge clock);
    bus.dividend = {16'd255, 16'd100};
    bus.divisor  = {16'd16, 16'd10};
    bus.req      = 2'b11;
    #1;
    chk("rr.grant0", bus.grant, 2'b01);
    wait_done(n);
    chk("rr.lat0", n, 17);
    chk("rr.done0", bus.done, 2'b01);
    chk("rr.q0", bus.quotient, 10);
    @(negedge clock);
    bus.req[0] = 1'b0;
    #1;
    chk("rr.grant1", bus.grant, 2'b10);
    wait_done(n);
    chk("rr.lat1", n, 17);
    chk("rr.done1", bus.done, 2'b10);
    chk("rr.q1", bus.quotient, R ? 16 : 15);
    @(negedge clock);
    bus.req = 2'b11;
    #1;
    chk("rr.regrant0", bus.grant, 2'b01);
    wait_done(n);
    chk("rr.redone0", bus.done, 2'b01);
    @(negedge clock);
    bus.req[0] = 1'b0;
    #1;
    chk("rr.regrant1", bus.grant, 2'b10);
    wait_done(n);
    chk("rr.redone1", bus.done, 2'b10);
    @(negedge clock);
    bus.req = '0;

    do_op("t1", 0, 1000, 7, R ? 143 : 142, 0, 0);
    do_op("t2", 1, 5000, 0, 4095, 1, 0);
    do_op("t3", 0, 65535, 1, 4095, 0, 1);
    do_op("max", 1, 4095, 1, 4095, 0, 0);
    do_op("over", 0, 4096, 1, 4095, 0, 1);
    do_op("half_lo", 1, 8189, 2, R ? 4095 : 4094, 0, 0);
    do_op("half_hi", 0, 8191, 2, 4095, 0, R);
    do_op("zero", 1, 0, 5, 0, 0, 0);

    // Reset five cycles into DIV.
    @(negedge clock);
    bus.dividend[IW-1:0] = 16'd1000;
    bus.divisor[IW-1:0]  = 16'd7;
    bus.req[0]           = 1'b1;
    #1;
    chk("rst5.grant", bus.grant, 2'b01);
    repeat (5) @(negedge clock);
    chk("rst5.busy_before", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("rst5.busy", bus.busy, 0);
    chk("rst5.grant0", bus.grant, 0);
    chk("rst5.done", bus.done, 0);
    chk("rst5.quotient", bus.quotient, 0);
    bus.req = '0;
    @(negedge clock);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (25) begin
      @(negedge clock);
      seen = seen | (|bus.done);
    end
    chk("rst5.no_done", seen, 0);
    do_op("rst5.fresh", 1, 1000, 7, R ? 143 : 142, 0, 0);

    // Drop req and change operands after grant.
    @(negedge clock);
    bus.dividend[IW-1:0] = 16'd1000;
    bus.divisor[IW-1:0]  = 16'd7;
    bus.req[0]           = 1'b1;
    #1;
    chk("t6.grant", bus.grant, 2'b01);
    @(negedge clock);
    bus.req[0]           = 1'b0;
    bus.dividend[IW-1:0] = 16'd50000;
    bus.divisor[IW-1:0]  = 16'd3;
    wait_done(n);
    chk("t6.latency", n + 1, 17);
    chk("t6.done", bus.done, 2'b01);
    chk("t6.quotient", bus.quotient, R ? 143 : 142);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
